board_link: RTL
===============

BOARD_LINK -- requirements
Module: board_link

Interface
REQ-001 Parameter DATA_W, default 9, payload bits per transfer (min 1).
REQ-002 Parameter SYNC_STAGES, default 2, input synchroniser depth (min 2).
REQ-003 Parameter TIMEOUT_CYC, default 1023, cycles waited for remote ack before error (min 1).
REQ-004 Port clk  in  1  single system clock, all logic on rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port tx_data  in  DATA_W  word to send, sampled when tx_valid and tx_ready are both high.
REQ-007 Port tx_valid  in  1  sender request.
REQ-008 Port tx_ready  out  1  block can accept a word.
REQ-009 Port rx_data  out  DATA_W  last received word, held until the next reception.
REQ-010 Port rx_valid  out  1  one-cycle pulse, new rx_data.
REQ-011 Port link_in  in  DATA_W+2  raw pins from remote board: {req_tgl, ack_tgl, data}.
REQ-012 Port link_out  out  DATA_W+2  pins to remote board: {req_tgl, ack_tgl, data}.
REQ-013 Port tx_err  out  1  sticky timeout flag, cleared by the next accepted tx word.
REQ-014 Port busy  out  1  high while a transfer awaits ack.

Function
REQ-015 link_in SHALL pass through SYNC_STAGES flip-flops before any use.
REQ-016 TX FSM SHALL have states IDLE, WAIT_ACK; tx_ready = (state==IDLE), busy = (state==WAIT_ACK).
REQ-017 In IDLE, on tx_valid: register tx_data onto link_out data, then invert link_out req_tgl one cycle later (data settles first), enter WAIT_ACK, clear tx_err.
REQ-018 In WAIT_ACK, when synchronised remote ack_tgl equals local req_tgl: return to IDLE, clear timeout counter.
REQ-019 In WAIT_ACK, counter reaching TIMEOUT_CYC SHALL set tx_err and return to IDLE; req_tgl is not re-inverted.
REQ-020 link_out data SHALL remain stable from req_tgl inversion until return to IDLE.
REQ-021 RX: on synchronised remote req_tgl differing from previous sampled value, capture synchronised data into rx_data, pulse rx_valid for exactly one cycle, and invert link_out ack_tgl in the same cycle.
REQ-022 RX and TX SHALL operate concurrently and independently; simultaneous send and receive in one cycle SHALL both complete.
REQ-023 tx_valid while tx_ready low SHALL be ignored (no queueing).
REQ-024 Timeout counter width SHALL be $clog2(TIMEOUT_CYC+1); no wrap before TIMEOUT_CYC.
REQ-025 Latency tx handshake -> remote rx_valid SHALL be 1 + SYNC_STAGES + 1 cycles with same-clock boards.

Reset
REQ-026 rst SHALL force: state IDLE, link_out all zero, rx_data zero, rx_valid 0, tx_err 0, synchroniser chains and previous-toggle registers zero, counter zero.
REQ-027 Reset asserted mid-transfer SHALL abort it with no rx_valid or tx_err generated by the abort.
REQ-028 After reset release the first remote toggle edge SHALL be treated as a valid new word.

Structure
REQ-029 Shared package board_link_pkg SHALL hold the TX state enum and the field-index constants for the {req, ack, data} pin packing.
REQ-030 Sub-module sync_chain (parametrised width and depth) SHALL implement the input synchroniser.
REQ-031 Top-level FPGA wrapper SHALL map board pins to link_in/link_out with DATA_W = 9.

Verification
REQ-032 Loopback link_out->link_in, send 9'h1A5 -> rx_valid one pulse with rx_data 9'h1A5, tx_ready back high, tx_err 0.
REQ-033 Two instances cross-connected, each sends simultaneously (9'h055, 9'h0AA) -> each receives the other's word, exactly one rx_valid each.
REQ-034 link_in tied to zero, TIMEOUT_CYC=15, send one word -> tx_err high after 15 WAIT_ACK cycles, tx_ready high next cycle; next send clears tx_err.
REQ-035 Back-to-back 8 words in loopback -> 8 rx_valid pulses, data in order, none lost.
REQ-036 rst pulsed during WAIT_ACK -> all outputs reset values, no rx_valid, no tx_err.
REQ-037 tx_valid held high during WAIT_ACK with changing tx_data -> link_out data unchanged until ack.

Source files
------------

// File: rtl/board_link_pkg.sv
// Shared types and pin-packing helpers for the board-to-board toggle link.
// Pin vector layout is {req_tgl, ack_tgl, data}, with the toggle bits just above the data field.
package board_link_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } tx_state_t;

  // Toggle-bit positions relative to the top of the data field.
  localparam int ACK_OFS = 0;
  localparam int REQ_OFS = 1;

  function automatic int ack_idx(input int data_w);
    return data_w + ACK_OFS;
  endfunction

  function automatic int req_idx(input int data_w);
    return data_w + REQ_OFS;
  endfunction

endpackage

// File: rtl/board_link_fpga.sv
// FPGA top: maps the 11 link pins and user I/O of one board onto a 9-bit board_link.
module board_link_fpga (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  sw_data,
  input  logic        btn_send,
  output logic        led_ready,
  output logic        led_busy,
  output logic        led_err,
  output logic        led_rx_valid,
  output logic [8:0]  led_rx,
  input  logic [10:0] pin_in,
  output logic [10:0] pin_out
);

  board_link #(
    .DATA_W (9)
  ) u_link (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (sw_data),
    .tx_valid (btn_send),
    .tx_ready (led_ready),
    .rx_data  (led_rx),
    .rx_valid (led_rx_valid),
    .link_in  (pin_in),
    .link_out (pin_out),
    .tx_err   (led_err),
    .busy     (led_busy)
  );

endmodule

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for asynchronous board pins.
// Every bit passes through DEPTH registers before the core logic sees it.
module sync_chain #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // NOTE: sequential state uses <= so each flop samples its pre-edge input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the stage array is reset on purpose; stale toggles left in it would look like a new word.
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/board_link.sv
// Two-wire toggle handshake link: sends one word per req toggle and acks received words.
// TX and RX halves share only the synchronised pin vector.
module board_link
  import board_link_pkg::*;
#(
  parameter int DATA_W      = 9,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W+1:0] link_in,
  output logic [DATA_W+1:0] link_out,
  output logic              tx_err,
  output logic              busy
);

  localparam int LINK_W  = DATA_W + 2;
  localparam int ACK_BIT = ack_idx(DATA_W);
  localparam int REQ_BIT = req_idx(DATA_W);
  localparam int CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [LINK_W-1:0] link_sync;
  logic              remote_req;
  logic              remote_ack;

  sync_chain #(
    .WIDTH (LINK_W),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (link_in),
    .q   (link_sync)
  );

  assign remote_req = link_sync[REQ_BIT];
  assign remote_ack = link_sync[ACK_BIT];

  // ---------------- TX ----------------
  tx_state_t         state, state_next;
  logic              req_tgl, req_pend;
  logic              ack_tgl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  cnt;
  logic              accept, ack_seen, timeout;

  // req_pend marks the cycle where data is already driven but req has not toggled yet,
  // so the stale req==ack equality must not be taken as an ack.
  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    state_next = state;
    accept     = 1'b0;
    ack_seen   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          accept     = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!req_pend && (remote_ack == req_tgl)) begin
          ack_seen   = 1'b1;
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_tgl  <= 1'b0;
      req_pend <= 1'b0;
      out_data <= '0;
      cnt      <= '0;
      tx_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        out_data <= tx_data;
        req_pend <= 1'b1;
        tx_err   <= 1'b0;
        cnt      <= '0;
      end
      if (req_pend) begin
        req_tgl  <= ~req_tgl;
        req_pend <= 1'b0;
      end
      if (state == WAIT_ACK) begin
        if (ack_seen || timeout) cnt <= '0;
        else                     cnt <= cnt + 1'b1;
        if (timeout) tx_err <= 1'b1;
      end
    end
  end

  assign tx_ready = (state == IDLE);
  assign busy     = (state == WAIT_ACK);

  // ---------------- RX ----------------
  logic req_prev;
  logic rx_new;

  assign rx_new = remote_req ^ req_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_prev <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      ack_tgl  <= 1'b0;
    end else begin
      req_prev <= remote_req;
      rx_valid <= rx_new;
      if (rx_new) begin
        rx_data <= link_sync[DATA_W-1:0];
        ack_tgl <= ~ack_tgl;
      end
    end
  end

  assign link_out = {req_tgl, ack_tgl, out_data};

endmodule
